// File: rtl/g_hit_detect_pkg.sv
// g_hit_detect_pkg: shared FSM state and draw-mux mode codes for the Zapper hit test.
package g_hit_detect_pkg;
    typedef enum logic [2:0] {G_ST_IDLE, G_ST_ARM, G_ST_BLACK, G_ST_TARGET, G_ST_DONE} g_state_t;
    typedef enum logic [1:0] {G_DRAW_NORMAL, G_DRAW_BLACK, G_DRAW_TARGET} g_draw_t;
endpackage

// File: rtl/g_hit_detect_light_sampler.sv
// g_hit_detect_light_sampler: synchronises GUN_Light and flags a long enough run of light after display settle.
module g_hit_detect_light_sampler #(
    parameter int SETTLE_CYCLES = 512,
    parameter int LIGHT_MIN     = 64
) (
    input  logic SYSTEM_Clock,
    input  logic SYSTEM_Rst_n,
    input  logic GUN_Light,
    input  logic clear,
    input  logic frame_start,
    output logic seen
);
    localparam int RW = $clog2(LIGHT_MIN + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    logic [1:0]    sync;
    logic [SW-1:0] settle;
    logic [RW-1:0] run;
    logic          light_s, inhibit;
    assign light_s = ~sync[1];
    assign inhibit = frame_start | (settle != '0);
    // sync resets to "dark" so no phantom light right after reset
    always_ff @(posedge SYSTEM_Clock or negedge SYSTEM_Rst_n) begin
        if (!SYSTEM_Rst_n) begin
            sync   <= 2'b11;
            settle <= '0;
            run    <= '0;
            seen   <= 1'b0;
        end else begin
            sync   <= {sync[0], GUN_Light};
            settle <= frame_start ? SW'(SETTLE_CYCLES) : (settle != '0 ? settle - SW'(1) : settle);
            run    <= (clear | inhibit | ~light_s) ? '0 : (run == RW'(LIGHT_MIN) ? run : run + RW'(1));
            seen   <= ~clear & (seen | (run == RW'(LIGHT_MIN)));
        end
    end
endmodule

// File: rtl/g_hit_detect.sv
// g_hit_detect: Zapper shot sequencer (black frames, target frames, hit result handshake).
// Define G_AMBIENT_CHECK_EN to fault shots that see light during the black frames.
module g_hit_detect
    import g_hit_detect_pkg::*;
#(
    parameter int BLACK_FRAMES  = 1,
    parameter int TARGET_FRAMES = 1,
    parameter int SETTLE_CYCLES = 512,
    parameter int LIGHT_MIN     = 64
) (
    input  logic SYSTEM_Clock,
    input  logic SYSTEM_Rst_n,
    input  logic Trigger_Pull,
    input  logic GUN_Light,
    input  logic Frame_Start,
    input  logic Result_Read,
    output logic Flash_Black,
    output logic Flash_Target,
    output logic Busy,
    output logic Result_Valid,
`ifdef G_AMBIENT_CHECK_EN
    output logic Ambient_Fault,
`endif
    output logic Hit
);
    g_state_t   state, next;
    g_draw_t    draw;
    logic [3:0] frame_cnt;
    logic       trig_d, trig_edge, clear, last_frame, seen, hit, amb;
    assign trig_edge = Trigger_Pull & ~trig_d;
    assign clear     = next != state;
    always_comb begin
        next       = state;
        last_frame = Frame_Start && frame_cnt ==
                     (state == G_ST_BLACK ? 4'(BLACK_FRAMES - 1) : 4'(TARGET_FRAMES - 1));
        case (state)
            G_ST_IDLE:   next = trig_edge   ? G_ST_ARM    : state;
            G_ST_ARM:    next = Frame_Start ? G_ST_BLACK  : state;
            G_ST_BLACK:  next = last_frame  ? G_ST_TARGET : state;
            G_ST_TARGET: next = last_frame  ? G_ST_DONE   : state;
            G_ST_DONE:   next = Result_Read ? G_ST_IDLE   : state;
            default:     next = G_ST_IDLE;
        endcase
    end
    always_ff @(posedge SYSTEM_Clock or negedge SYSTEM_Rst_n) begin
        if (!SYSTEM_Rst_n) begin
            state     <= G_ST_IDLE;
            trig_d    <= 1'b0;
            frame_cnt <= '0;
            hit       <= 1'b0;
        end else begin
            state     <= next;
            trig_d    <= Trigger_Pull;
            frame_cnt <= clear ? '0 : frame_cnt + 4'(Frame_Start && (state == G_ST_BLACK || state == G_ST_TARGET));
            hit       <= state == G_ST_TARGET ? seen : hit;
        end
    end
`ifdef G_AMBIENT_CHECK_EN
    always_ff @(posedge SYSTEM_Clock or negedge SYSTEM_Rst_n) begin
        if (!SYSTEM_Rst_n) amb <= 1'b0;
        else amb <= state == G_ST_BLACK ? seen : amb;
    end
    assign Ambient_Fault = (state == G_ST_DONE) & amb;
`else
    assign amb = 1'b0;
`endif
    g_hit_detect_light_sampler #(.SETTLE_CYCLES(SETTLE_CYCLES), .LIGHT_MIN(LIGHT_MIN)) u_sampler (
        .SYSTEM_Clock (SYSTEM_Clock),
        .SYSTEM_Rst_n (SYSTEM_Rst_n),
        .GUN_Light    (GUN_Light),
        .clear        (clear),
        .frame_start  (Frame_Start),
        .seen         (seen)
    );
    assign draw         = state == G_ST_BLACK ? G_DRAW_BLACK : (state == G_ST_TARGET ? G_DRAW_TARGET : G_DRAW_NORMAL);
    assign Flash_Black  = draw == G_DRAW_BLACK;
    assign Flash_Target = draw == G_DRAW_TARGET;
    assign Busy         = state == G_ST_ARM || state == G_ST_BLACK || state == G_ST_TARGET;
    assign Result_Valid = state == G_ST_DONE;
    assign Hit          = (state == G_ST_DONE) & hit & ~amb;
endmodule

// File: tb/tb_g_hit_detect.sv
// tb_g_hit_detect: directed scenario tests for g_hit_detect.
module tb_g_hit_detect;
    localparam int FRAME = 800;
    logic SYSTEM_Clock, SYSTEM_Rst_n, Trigger_Pull, GUN_Light, Frame_Start, Result_Read;
    logic Flash_Black, Flash_Target, Busy, Result_Valid, Hit, Ambient_Fault;
    logic [4:0] outs, mid_outs;
    int errors = 0;
    int checks = 0;
    assign outs = {Flash_Black, Flash_Target, Busy, Result_Valid, Hit};

    g_hit_detect dut (
        .SYSTEM_Clock (SYSTEM_Clock),
        .SYSTEM_Rst_n (SYSTEM_Rst_n),
        .Trigger_Pull (Trigger_Pull),
        .GUN_Light    (GUN_Light),
        .Frame_Start  (Frame_Start),
        .Result_Read  (Result_Read),
        .Flash_Black  (Flash_Black),
        .Flash_Target (Flash_Target),
        .Busy         (Busy),
        .Result_Valid (Result_Valid),
`ifdef G_AMBIENT_CHECK_EN
        .Ambient_Fault(Ambient_Fault),
`endif
        .Hit          (Hit)
    );
`ifndef G_AMBIENT_CHECK_EN
    assign Ambient_Fault = 1'b0;
`endif

    initial SYSTEM_Clock = 1'b0;
    always #20 SYSTEM_Clock = ~SYSTEM_Clock;

    task automatic tick();
        @(posedge SYSTEM_Clock);
        #1;
    endtask

    // one frame: Frame_Start on cycle 0, light (GUN_Light=0) in [ls, ls+ll), trigger pulse at cycle ta
    task automatic frame(input int ls, input int ll, input int ta);
        for (int c = 0; c < FRAME; c++) begin
            Frame_Start  = (c == 0);
            GUN_Light    = !(c >= ls && c < ls + ll);
            Trigger_Pull = (c == ta);
            if (c == 400) mid_outs = outs;
            tick();
        end
        Frame_Start  = 1'b0;
        GUN_Light    = 1'b1;
        Trigger_Pull = 1'b0;
    endtask

    task automatic run_shot(input int bs, input int bl, input int ts, input int tl,
                            output logic [4:0] ob, output logic [4:0] ot,
                            output logic [4:0] pe, output logic [4:0] res, output logic af);
        Trigger_Pull = 1'b1;
        tick();
        Trigger_Pull = 1'b0;
        frame(bs, bl, -1);
        ob = mid_outs;
        frame(ts, tl, -1);
        ot = mid_outs;
        pe = outs;
        Frame_Start = 1'b1;
        tick();
        Frame_Start = 1'b0;
        res = outs;
        af  = Ambient_Fault;
    endtask

    task automatic do_read();
        Result_Read = 1'b1;
        tick();
        Result_Read = 1'b0;
    endtask

    task automatic test_reset();
        SYSTEM_Rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, 5'b00000); end
        checks++;
        if (Ambient_Fault !== 1'b0) begin errors++; $display("FAIL reset_amb: got %b want %b", Ambient_Fault, 1'b0); end
        SYSTEM_Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_target();
        logic [4:0] ob, ot, pe, res;
        logic af;
        Trigger_Pull = 1'b1;
        tick();
        Trigger_Pull = 1'b0;
        frame(-1, 0, -1);
        Frame_Start = 1'b1;
        tick();
        Frame_Start = 1'b0;
        repeat (100) tick();
        checks++;
        if (outs !== 5'b01100) begin errors++; $display("FAIL pre_reset_target: got %b want %b", outs, 5'b01100); end
        SYSTEM_Rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL async_reset: got %b want %b", outs, 5'b00000); end
        repeat (3) tick();
        SYSTEM_Rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL post_reset_idle: got %b want %b", outs, 5'b00000); end
        run_shot(-1, 0, 600, 100, ob, ot, pe, res, af);
        checks++;
        if (res !== 5'b00011) begin errors++; $display("FAIL clean_shot_hit: got %b want %b", res, 5'b00011); end
        do_read();
    endtask

    task automatic test_basic_miss();
        logic [4:0] ob, ot, pe, res;
        logic af;
        run_shot(-1, 0, -1, 0, ob, ot, pe, res, af);
        checks++;
        if (ob !== 5'b10100) begin errors++; $display("FAIL black_frame: got %b want %b", ob, 5'b10100); end
        checks++;
        if (ot !== 5'b01100) begin errors++; $display("FAIL target_frame: got %b want %b", ot, 5'b01100); end
        checks++;
        if (pe !== 5'b01100) begin errors++; $display("FAIL valid_latency: got %b want %b", pe, 5'b01100); end
        checks++;
        if (res !== 5'b00010) begin errors++; $display("FAIL dark_miss: got %b want %b", res, 5'b00010); end
        repeat (5) tick();
        checks++;
        if (outs !== 5'b00010) begin errors++; $display("FAIL result_held: got %b want %b", outs, 5'b00010); end
        do_read();
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL read_clears: got %b want %b", outs, 5'b00000); end
    endtask

    task automatic test_threshold();
        logic [4:0] ob, ot, pe, res;
        logic af;
        run_shot(-1, 0, 600, 100, ob, ot, pe, res, af);
        checks++;
        if (res !== 5'b00011) begin errors++; $display("FAIL light100_hit: got %b want %b", res, 5'b00011); end
        do_read();
        run_shot(-1, 0, 600, 63, ob, ot, pe, res, af);
        checks++;
        if (res !== 5'b00010) begin errors++; $display("FAIL light63_miss: got %b want %b", res, 5'b00010); end
        do_read();
    endtask

    task automatic test_settle();
        logic [4:0] ob, ot, pe, res;
        logic af;
        run_shot(-1, 0, 10, 100, ob, ot, pe, res, af);
        checks++;
        if (res !== 5'b00010) begin errors++; $display("FAIL settle_miss: got %b want %b", res, 5'b00010); end
        do_read();
    endtask

    task automatic test_ambient();
        logic [4:0] ob, ot, pe, res;
        logic af;
        run_shot(600, 100, 600, 100, ob, ot, pe, res, af);
`ifdef G_AMBIENT_CHECK_EN
        checks++;
        if (res !== 5'b00010) begin errors++; $display("FAIL ambient_hit: got %b want %b", res, 5'b00010); end
        checks++;
        if (af !== 1'b1) begin errors++; $display("FAIL ambient_fault: got %b want %b", af, 1'b1); end
`else
        checks++;
        if (res !== 5'b00011) begin errors++; $display("FAIL ambient_hit: got %b want %b", res, 5'b00011); end
        checks++;
        if (af !== 1'b0) begin errors++; $display("FAIL ambient_fault: got %b want %b", af, 1'b0); end
`endif
        do_read();
        checks++;
        if (Ambient_Fault !== 1'b0) begin errors++; $display("FAIL ambient_cleared: got %b want %b", Ambient_Fault, 1'b0); end
    endtask

    task automatic test_trigger_ignore();
        Trigger_Pull = 1'b1;
        tick();
        Trigger_Pull = 1'b0;
        tick();
        Trigger_Pull = 1'b1;
        tick();
        Trigger_Pull = 1'b0;
        tick();
        checks++;
        if (outs !== 5'b00100) begin errors++; $display("FAIL arm_retrigger: got %b want %b", outs, 5'b00100); end
        frame(-1, 0, 300);
        frame(600, 100, 300);
        Frame_Start = 1'b1;
        tick();
        Frame_Start = 1'b0;
        checks++;
        if (outs !== 5'b00011) begin errors++; $display("FAIL retrigger_result: got %b want %b", outs, 5'b00011); end
        Trigger_Pull = 1'b1;
        tick();
        Trigger_Pull = 1'b0;
        tick();
        checks++;
        if (outs !== 5'b00011) begin errors++; $display("FAIL done_trigger: got %b want %b", outs, 5'b00011); end
        Trigger_Pull = 1'b1;
        Result_Read  = 1'b1;
        tick();
        Result_Read = 1'b0;
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL read_with_trigger: got %b want %b", outs, 5'b00000); end
        repeat (5) tick();
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL held_trigger: got %b want %b", outs, 5'b00000); end
        Trigger_Pull = 1'b0;
        Frame_Start  = 1'b1;
        Result_Read  = 1'b1;
        tick();
        Frame_Start = 1'b0;
        Result_Read = 1'b0;
        repeat (2) tick();
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL idle_ignores: got %b want %b", outs, 5'b00000); end
    endtask

    task automatic test_same_cycle_frame();
        Trigger_Pull = 1'b1;
        Frame_Start  = 1'b1;
        tick();
        Trigger_Pull = 1'b0;
        Frame_Start  = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs !== 5'b00100) begin errors++; $display("FAIL same_cycle_frame: got %b want %b", outs, 5'b00100); end
        frame(-1, 0, -1);
        checks++;
        if (mid_outs !== 5'b10100) begin errors++; $display("FAIL next_frame_black: got %b want %b", mid_outs, 5'b10100); end
        frame(-1, 0, -1);
        Frame_Start = 1'b1;
        tick();
        Frame_Start = 1'b0;
        checks++;
        if (outs !== 5'b00010) begin errors++; $display("FAIL same_cycle_result: got %b want %b", outs, 5'b00010); end
        do_read();
    endtask

    initial begin
        Trigger_Pull = 1'b0;
        GUN_Light    = 1'b1;
        Frame_Start  = 1'b0;
        Result_Read  = 1'b0;
        test_reset();
        test_reset_mid_target();
        test_basic_miss();
        test_threshold();
        test_settle();
        test_ambient();
        test_trigger_ignore();
        test_same_cycle_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
